uart_boot_loader: RTL and testbench
===================================

// Module: uart_boot_loader
// PURPOSE
//  UART program/data loader sitting upstream of programrom and memory: receives an 8N1 serial
//  image on rx after start_pg, assembles little-endian 32-bit words, and drives the upg_* write
//  port of both memories. upg_done_o low holds the CPU off the memories while an upload runs.
// PARAMETERS
//  CLK_HZ       10_000_000  clk frequency in Hz
//  BAUD         115_200     UART bit rate; DIV = CLK_HZ/BAUD (integer division), HALF = DIV/2
//  TIMEOUT_CYC  2_000_000   max idle clk cycles between bytes while loading before abort
// PORTS
//  clk          in   1   single system clock, all logic on posedge
//  rst          in   1   synchronous reset, active-low
//  start_pg     in   1   level from button; a rising edge arms an upload
//  rx           in   1   UART serial input, idle high, asynchronous
//  upg_wen_o    out  1   one-cycle write strobe to programrom/memory
//  upg_adr_o    out  15  [14]=region (0 program ROM, 1 data memory), [13:0]=word index
//  upg_dat_o    out  32  word to write
//  upg_done_o   out  1   1 = no upload in progress, CPU may run
//  upg_busy_o   out  1   1 = loader in HDR/DATA states
//  upg_err_o    out  1   sticky: framing error, bad header or timeout; cleared by start_pg edge
// BEHAVIOUR
//  Reset (rst==0 at posedge): wen=0, adr=0, dat=0, done=1, busy=0, err=0; both FSMs to idle;
//   partial byte/word discarded. Reset mid-upload aborts it with no further writes.
//  rx passes a 2-FF synchronizer before use; start_pg registered once for edge detect.
//  RX FSM:
//   R_IDLE : synced rx 1->0 transition -> R_START, counter=0.
//   R_START: after HALF cycles sample; 1 -> R_IDLE (glitch, no byte); 0 -> R_DATA.
//   R_DATA : sample every DIV cycles, LSB first, 8 bits -> R_STOP.
//   R_STOP : after DIV cycles sample; 1 -> byte_valid pulse 1 cycle; 0 -> err=1, byte dropped.
//            Both -> R_IDLE. Next start requires rx seen high first.
//  Loader FSM (consumes byte_valid):
//   L_IDLE : start_pg rising edge -> L_HDR, done=0, busy=1, err=0, word index=0, byte cnt=0.
//            Bytes arriving in L_IDLE are ignored.
//   L_HDR  : 3 bytes: b0[0]=region (b0[7:1] ignored), N={b2,b1}. If N[15:14]!=0 -> err=1,
//            L_IDLE. If N==0 -> L_IDLE. Otherwise -> L_DATA.
//   L_DATA : 4 bytes per word, first byte = bits[7:0]. Cycle after the 4th byte_valid:
//            wen=1 for exactly one cycle, adr={region,index}, dat=word; index++. adr/dat hold
//            until next write. After word N-1 written -> L_IDLE.
//   Return to L_IDLE in all cases: done=1 and busy=0 on the cycle after the last wen (or the
//   abort), never in the same cycle as a wen.
//  start_pg edges while busy are ignored. A framing error in HDR/DATA sets err and aborts
//   (-> L_IDLE). Inter-byte counter resets on every byte_valid; reaching TIMEOUT_CYC in
//   HDR/DATA -> err=1, abort. Words already written stay written.
//  Index is 14 bits; N<=16383 guarantees no wrap.
// TESTING (bench: CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10, TIMEOUT_CYC=500)
//  1 start_pg edge, bytes 00 02 00 78 56 34 12 EF BE AD DE -> wen at adr 0x0000 dat
//    0x12345678, then adr 0x0001 dat 0xDEADBEEF; done 0->1 one cycle after 2nd wen; err=0.
//  2 header 01 01 00, bytes 44 33 22 11 -> single wen adr 0x4000 dat 0x11223344.
//  3 rx low pulse 3 cycles, then byte 0x55 with stop bit=0 -> no byte from glitch;
//    err=1, no wen.
//  4 header 00 00 40 (N=0x4000) -> err=1, done=1, no wen; header 00 00 00 -> done=1, no wen.
//  5 header 00 02 00, one full word, then silence 500 cycles -> one wen at 0x0000,
//    then err=1, done=1.
//  6 rst low after 2 data bytes, release, resend full case 1 -> no wen before rst; case 1
//    results exact.

Source files
------------

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_boot_loader
// Description : UART 8N1 image loader. Receives a 3-byte header (region,
//               word count) followed by little-endian 32-bit words and
//               writes them through the upg_* port into program ROM or data
//               memory. upg_done_o low holds the CPU off the memories.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
  parameter int CLK_HZ      = 10_000_000,
  parameter int BAUD        = 115_200,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pg,
  input  logic        rx,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_busy_o,
  output logic        upg_err_o
);

  localparam int c_div  = CLK_HZ / BAUD;
  localparam int c_half = c_div / 2;
  localparam int c_cw   = $clog2(c_div + 1);
  localparam int c_tw   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [c_cw-1:0] c_div_last  = c_cw'(c_div - 1);
  localparam logic [c_cw-1:0] c_half_last = c_cw'(c_half - 1);
  localparam logic [c_tw-1:0] c_to_last   = c_tw'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_HDR, L_DATA}           ld_state_t;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic r_rx_meta, r_rx_sync, r_rx_prev, r_start_q;
  logic w_start_edge;

  // Two-flop synchronizer on rx, one extra stage for falling-edge detect,
  // and a single register on start_pg for rising-edge detect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_start_q <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_start_q <= start_pg;
    end
  end

  assign w_start_edge = start_pg & ~r_start_q;

  // --------------------------------------------------------------------------
  // UART receiver
  // --------------------------------------------------------------------------
  rx_state_t       rx_state, rx_nxt;
  logic [c_cw-1:0] r_rx_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_rx_shift;
  logic            w_rx_tick, w_byte_valid, w_frame_err;

  // Receiver next-state: sample start bit mid-bit, then every bit period.
  always_comb begin
    rx_nxt       = rx_state;
    w_rx_tick    = 1'b0;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (r_rx_prev && !r_rx_sync) rx_nxt = R_START;
      end
      R_START: begin
        if (r_rx_cnt == c_half_last) rx_nxt = r_rx_sync ? R_IDLE : R_DATA;
      end
      R_DATA: begin
        if (r_rx_cnt == c_div_last) begin
          w_rx_tick = 1'b1;
          if (r_bit_cnt == 3'd7) rx_nxt = R_STOP;
        end
      end
      R_STOP: begin
        if (r_rx_cnt == c_div_last) begin
          rx_nxt = R_IDLE;
          if (r_rx_sync) w_byte_valid = 1'b1;
          else           w_frame_err  = 1'b1;
        end
      end
      default: rx_nxt = R_IDLE;
    endcase
  end

  // Receiver state, bit-period counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state   <= R_IDLE;
      r_rx_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
    end else begin
      rx_state <= rx_nxt;
      if (rx_state == R_IDLE || rx_nxt != rx_state || w_rx_tick)
        r_rx_cnt <= '0;
      else
        r_rx_cnt <= r_rx_cnt + c_cw'(1);
      if (rx_state == R_START) r_bit_cnt <= '0;
      if (w_rx_tick) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Loader
  // --------------------------------------------------------------------------
  ld_state_t       ld_state, ld_nxt;
  logic [1:0]      r_byte_cnt;
  logic            r_region;
  logic [13:0]     r_n;
  logic [13:0]     r_idx;
  logic [31:0]     r_word;
  logic [c_tw-1:0] r_to_cnt;
  logic            r_wen, r_err;
  logic [14:0]     r_adr;
  logic [31:0]     r_dat;
  logic [15:0]     w_hdr_n;
  logic            w_timeout, w_set_err, w_arm, w_fire;

  assign w_hdr_n   = {r_rx_shift, r_n[7:0]};
  assign w_timeout = (r_to_cnt == c_to_last);

  // Loader next-state: header parse, word assembly, completion and aborts.
  always_comb begin
    ld_nxt    = ld_state;
    w_set_err = 1'b0;
    w_arm     = 1'b0;
    w_fire    = 1'b0;
    case (ld_state)
      L_IDLE: begin
        if (w_start_edge) begin
          ld_nxt = L_HDR;
          w_arm  = 1'b1;
        end
      end
      L_HDR: begin
        if (w_frame_err || w_timeout) begin
          w_set_err = 1'b1;
          ld_nxt    = L_IDLE;
        end else if (w_byte_valid && r_byte_cnt == 2'd2) begin
          if (w_hdr_n[15:14] != 2'b00) begin
            w_set_err = 1'b1;
            ld_nxt    = L_IDLE;
          end else if (w_hdr_n == 16'd0) begin
            ld_nxt = L_IDLE;
          end else begin
            ld_nxt = L_DATA;
          end
        end
      end
      L_DATA: begin
        // r_idx already counts the word being strobed out this cycle.
        if (r_wen && r_idx == r_n) begin
          ld_nxt = L_IDLE;
        end else if (w_frame_err || w_timeout) begin
          w_set_err = 1'b1;
          ld_nxt    = L_IDLE;
        end else if (w_byte_valid && r_byte_cnt == 2'd3) begin
          w_fire = 1'b1;
        end
      end
      default: ld_nxt = L_IDLE;
    endcase
  end

  // Loader state, header fields, word assembly, write port and status.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_state   <= L_IDLE;
      r_byte_cnt <= '0;
      r_region   <= 1'b0;
      r_n        <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_to_cnt   <= '0;
      r_wen      <= 1'b0;
      r_err      <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
    end else begin
      ld_state <= ld_nxt;
      r_wen    <= w_fire;

      // Framing errors are sticky even while idle; a new upload clears them.
      if (w_arm)                        r_err <= 1'b0;
      else if (w_set_err || w_frame_err) r_err <= 1'b1;

      if (ld_state == L_IDLE || w_byte_valid) r_to_cnt <= '0;
      else if (!w_timeout)                    r_to_cnt <= r_to_cnt + c_tw'(1);

      if (w_arm) begin
        r_idx      <= '0;
        r_byte_cnt <= '0;
      end else if (w_byte_valid && ld_state == L_HDR) begin
        r_byte_cnt <= (r_byte_cnt == 2'd2) ? 2'd0 : r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0:    r_region  <= r_rx_shift[0];
          2'd1:    r_n[7:0]  <= r_rx_shift;
          default: r_n[13:8] <= r_rx_shift[5:0];
        endcase
      end else if (w_byte_valid && ld_state == L_DATA) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_word     <= {r_rx_shift, r_word[31:8]};
      end

      if (w_fire) begin
        r_adr <= {r_region, r_idx};
        r_dat <= {r_rx_shift, r_word[31:8]};
        r_idx <= r_idx + 14'd1;
      end
    end
  end

  assign upg_wen_o  = r_wen;
  assign upg_adr_o  = r_adr;
  assign upg_dat_o  = r_dat;
  assign upg_done_o = (ld_state == L_IDLE);
  assign upg_busy_o = (ld_state != L_IDLE);
  assign upg_err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_boot_loader
// Description : Self-checking bench for uart_boot_loader: directed upload
//               scenarios plus randomized images against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_pg = 1'b0;
  logic        rx = 1'b1;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o, upg_busy_o, upg_err_o;

  uart_boot_loader #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .TIMEOUT_CYC(500)
  ) dut (
    .clk(clk), .rst(rst), .start_pg(start_pg), .rx(rx),
    .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o),
    .upg_done_o(upg_done_o), .upg_busy_o(upg_busy_o), .upg_err_o(upg_err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_wen_cyc = -100;
  int done_rise_cyc = -100;
  int overlap = 0;
  logic prev_done = 1'b1;
  logic [46:0] act_q[$];
  logic [46:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the write port away from the active edge.
  always @(negedge clk) begin
    if (upg_wen_o === 1'b1) begin
      act_q.push_back({upg_adr_o, upg_dat_o});
      last_wen_cyc = cyc;
      if (upg_done_o === 1'b1) overlap++;
    end
    if (upg_done_o === 1'b1 && prev_done !== 1'b1) done_rise_cyc = cyc;
    prev_done = upg_done_o;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: derive expected writes and error from the image bytes.
  task automatic model(input logic [7:0] b[$], output logic e_err, output logic complete);
    int n;
    logic rg;
    logic [31:0] w;
    e_err = 1'b0;
    complete = 1'b1;
    if (b.size() < 3) begin
      e_err = 1'b1;
      complete = 1'b0;
      return;
    end
    rg = b[0][0];
    n  = int'(b[1]) + 256 * int'(b[2]);
    if (n >= 16384) begin
      e_err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (6 + 4 * k < b.size()) begin
        w = 32'(b[3+4*k]) + (32'(b[4+4*k]) << 8) + (32'(b[5+4*k]) << 16) + (32'(b[6+4*k]) << 24);
        exp_q.push_back({rg, 14'(k), w});
      end else begin
        e_err = 1'b1;
        complete = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop_bit;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    if (!stop_bit) repeat (20) @(negedge clk);
  endtask

  task automatic send_list(input logic [7:0] b[$], input int gap_max);
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], 1'b1);
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_pg = 1'b1;
    repeat (3) @(negedge clk);
    start_pg = 1'b0;
    @(negedge clk);
    check_val("armed_done", {63'd0, upg_done_o}, 64'd0);
    check_val("armed_busy", {63'd0, upg_busy_o}, 64'd1);
    check_val("armed_err",  {63'd0, upg_err_o},  64'd0);
  endtask

  task automatic finish_check(input string tag, input logic e_err, input logic complete);
    int nexp;
    logic [46:0] a, e;
    for (int i = 0; i < 700 && upg_done_o !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    nexp = exp_q.size();
    check_val({tag, "_done"}, {63'd0, upg_done_o}, 64'd1);
    check_val({tag, "_busy"}, {63'd0, upg_busy_o}, 64'd0);
    check_val({tag, "_err"},  {63'd0, upg_err_o},  {63'd0, e_err});
    check_val({tag, "_nwr"},  64'(act_q.size()),   64'(nexp));
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      check_val({tag, "_wr"}, {17'd0, a}, {17'd0, e});
    end
    if (complete && !e_err && nexp > 0)
      check_val({tag, "_done_lat"}, 64'(done_rise_cyc - last_wen_cyc), 64'd1);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic do_upload(input string tag, input logic [7:0] b[$], input int gap_max);
    logic e_err, complete;
    model(b, e_err, complete);
    pulse_start();
    send_list(b, gap_max);
    finish_check(tag, e_err, complete);
  endtask

  logic [7:0] case1[$] = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                           8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] case2[$] = '{8'h01, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    logic [7:0] img[$];
    logic e_err, complete;
    int n;

    // Reset values
    repeat (4) @(negedge clk);
    check_val("rst_wen",  {63'd0, upg_wen_o},  64'd0);
    check_val("rst_adr",  {49'd0, upg_adr_o},  64'd0);
    check_val("rst_dat",  {32'd0, upg_dat_o},  64'd0);
    check_val("rst_done", {63'd0, upg_done_o}, 64'd1);
    check_val("rst_busy", {63'd0, upg_busy_o}, 64'd0);
    check_val("rst_err",  {63'd0, upg_err_o},  64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Two-word program upload, then single data-memory word
    do_upload("c1", case1, 0);
    do_upload("c2", case2, 0);

    // A byte arriving while idle is ignored
    send_byte(8'hAA, 1'b1);
    repeat (5) @(negedge clk);
    check_val("idle_byte_nwr", 64'(act_q.size()), 64'd0);

    // Short rx glitch inside an upload must not produce a byte
    model(case2, e_err, complete);
    pulse_start();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    send_list(case2, 0);
    finish_check("glitch", e_err, complete);

    // Framing error while idle: sticky err, no write
    send_byte(8'h55, 1'b0);
    repeat (5) @(negedge clk);
    check_val("frame_err", {63'd0, upg_err_o}, 64'd1);
    check_val("frame_nwr", 64'(act_q.size()), 64'd0);

    // Oversized and zero-length headers
    img = '{8'h00, 8'h00, 8'h40};
    do_upload("bigN", img, 0);
    img = '{8'h00, 8'h00, 8'h00};
    do_upload("zeroN", img, 0);

    // Timeout after one of two words
    img = '{8'h00, 8'h02, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_upload("tmo", img, 0);

    // Reset in the middle of the data phase
    pulse_start();
    img = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56};
    send_list(img, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("mid_rst_done", {63'd0, upg_done_o}, 64'd1);
    check_val("mid_rst_busy", {63'd0, upg_busy_o}, 64'd0);
    check_val("mid_rst_nwr",  64'(act_q.size()),   64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    do_upload("c6", case1, 0);

    // Randomized images with random inter-byte gaps
    for (int it = 0; it < 8; it++) begin
      img.delete();
      n = $urandom_range(4, 1);
      img.push_back(8'($urandom));
      img.push_back(8'(n));
      img.push_back(8'h00);
      for (int j = 0; j < 4 * n; j++) img.push_back(8'($urandom));
      do_upload("rnd", img, 40);
    end

    check_val("wen_done_overlap", 64'(overlap), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
